// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the main-memory arbiter.
// Owner state encodings, requester IDs and the carry-lookahead add helper.
package mem_arbiter_pkg;

    localparam int ARB_BURST_LEN = 8;
    localparam int ARB_CNT_W     = 4;
    localparam int ARB_ADDR_W    = 16;
    localparam int ARB_DATA_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_I = 2'b01,
        OWN_D = 2'b10
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    // 4-bit carry-lookahead adder shared with the pipeline ALU.
    function automatic logic [3:0] cla_add4(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       cin
    );
        logic [2:0] g;
        logic [3:0] p;
        logic [3:0] c;
        g    = a[2:0] & b[2:0];
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0])
             | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        return p ^ c;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Memory-side bus between the arbiter and the main memory model.
// The arbiter is master; memory only returns the read-valid strobe.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic                  mem_enable;
    logic                  mem_wr;
    logic [ARB_ADDR_W-1:0] mem_addr;
    logic [ARB_DATA_W-1:0] mem_wdata;
    logic                  mem_data_valid;

    modport master (
        output mem_enable,
        output mem_wr,
        output mem_addr,
        output mem_wdata,
        input  mem_data_valid
    );

    modport slave (
        input  mem_enable,
        input  mem_wr,
        input  mem_addr,
        input  mem_wdata,
        output mem_data_valid
    );

endinterface

// File: rtl/mem_outstanding_ctr.sv
// Saturating up/down count of memory reads still awaiting data.
// next_zero lets the owner release in the cycle the last read returns.
module mem_outstanding_ctr
    import mem_arbiter_pkg::*;
#(
    parameter int BURST_LEN = ARB_BURST_LEN,
    parameter int CNT_W     = ARB_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             next_zero
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(BURST_LEN);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dec_ok;

    assign dec_ok = dec && (cnt_q != '0);

    // Decrement is an add of all-ones through the same adder.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec_ok && cnt_q != MAX) begin
            cnt_d = CNT_W'(cla_add4(4'(cnt_q), 4'h1, 1'b0));
        end else if (dec_ok && !inc) begin
            cnt_d = CNT_W'(cla_add4(4'(cnt_q), 4'hF, 1'b0));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count     = cnt_q;
    assign next_zero = (cnt_d == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin owner arbiter between the I-cache and D-cache for main memory.
// The grant is held for a whole fill until every outstanding read returns.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int BURST_LEN = ARB_BURST_LEN,
    parameter int CNT_W     = ARB_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic                  i_mem_enable,
    input  logic [ARB_ADDR_W-1:0] i_addr,
    output logic                  i_grant,
    output logic                  i_data_valid,
    input  logic                  d_req,
    input  logic                  d_mem_enable,
    input  logic                  d_wr,
    input  logic [ARB_ADDR_W-1:0] d_addr,
    input  logic [ARB_DATA_W-1:0] d_wdata,
    output logic                  d_grant,
    output logic                  d_data_valid,
    output logic                  d_wr_ack,
    mem_arbiter_if.master         mem,
    output logic                  spurious_valid
);

    arb_state_t       state_q;
    arb_state_t       state_d;
    req_id_t          served_q;
    req_id_t          served_d;
    logic             pick_i;
    logic             pick_d;
    logic             grant_i;
    logic             grant_d;
    logic             rd_issue;
    logic             ctr_zero;
    logic             ctr_next_zero;
    logic             valid_ok;
    logic             spur_q;
    logic [CNT_W-1:0] outstanding;

    mem_outstanding_ctr #(
        .BURST_LEN (BURST_LEN),
        .CNT_W     (CNT_W)
    ) u_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (rd_issue),
        .dec       (mem.mem_data_valid),
        .count     (outstanding),
        .next_zero (ctr_next_zero)
    );

    assign ctr_zero = (outstanding == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            served_q <= REQ_I;
        end else begin
            state_q  <= state_d;
            served_q <= served_d;
        end
    end

    // A tie goes to whoever was not served last.
    always_comb begin
        pick_i = 1'b0;
        pick_d = 1'b0;
        if (state_q == IDLE) begin
            if (i_req && d_req) begin
                pick_d = (served_q == REQ_I);
                pick_i = (served_q == REQ_D);
            end else begin
                pick_i = i_req;
                pick_d = d_req;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        served_d = served_q;
        unique case (state_q)
            IDLE: begin
                if (pick_i) begin
                    state_d = OWN_I;
                end else if (pick_d) begin
                    state_d = OWN_D;
                end
            end
            OWN_I: begin
                if (!i_req && ctr_next_zero) begin
                    state_d  = IDLE;
                    served_d = REQ_I;
                end
            end
            OWN_D: begin
                if (!d_req && ctr_next_zero) begin
                    state_d  = IDLE;
                    served_d = REQ_D;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grants are masked by rst_n so nothing leaks out while held in reset.
    always_comb begin
        grant_i = rst_n && (state_q == OWN_I || pick_i);
        grant_d = rst_n && (state_q == OWN_D || pick_d);

        mem.mem_enable = 1'b0;
        mem.mem_addr   = '0;
        if (grant_i) begin
            mem.mem_enable = i_mem_enable;
            mem.mem_addr   = i_addr;
        end else if (grant_d) begin
            mem.mem_enable = d_mem_enable;
            mem.mem_addr   = d_addr;
        end
        mem.mem_wr    = d_wr && grant_d;
        mem.mem_wdata = (grant_i || grant_d) ? d_wdata : '0;

        rd_issue = (grant_i && i_mem_enable)
                || (grant_d && d_mem_enable && !d_wr);
        d_wr_ack = grant_d && d_mem_enable && d_wr;

        valid_ok     = mem.mem_data_valid && !ctr_zero;
        i_data_valid = valid_ok && (state_q == OWN_I);
        d_data_valid = valid_ok && (state_q == OWN_D);

        i_grant = grant_i;
        d_grant = grant_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spur_q <= 1'b0;
        end else if (mem.mem_data_valid && ctr_zero) begin
            spur_q <= 1'b1;
        end
    end

    assign spurious_valid = spur_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed 4-cycle read-latency memory.
// Inputs change just after the rising edge; outputs are checked mid-cycle.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic        i_mem_enable;
    logic [15:0] i_addr;
    logic        i_grant;
    logic        i_data_valid;
    logic        d_req;
    logic        d_mem_enable;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_grant;
    logic        d_data_valid;
    logic        d_wr_ack;
    logic        spurious_valid;

    mem_arbiter_if mem ();

    mem_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req          (i_req),
        .i_mem_enable   (i_mem_enable),
        .i_addr         (i_addr),
        .i_grant        (i_grant),
        .i_data_valid   (i_data_valid),
        .d_req          (d_req),
        .d_mem_enable   (d_mem_enable),
        .d_wr           (d_wr),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_grant        (d_grant),
        .d_data_valid   (d_data_valid),
        .d_wr_ack       (d_wr_ack),
        .mem            (mem),
        .spurious_valid (spurious_valid)
    );

    int         nvec;
    int         nmis;
    logic [3:0] pipe;
    logic       issued;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Memory returns each read exactly four cycles after its strobe.
    task automatic tick();
        issued = mem.mem_enable & ~mem.mem_wr;
        @(posedge clk);
        #1;
        pipe = {pipe[2:0], issued};
        mem.mem_data_valid = pipe[3];
    endtask

    task automatic idle_inputs();
        i_req        = 1'b0;
        i_mem_enable = 1'b0;
        i_addr       = '0;
        d_req        = 1'b0;
        d_mem_enable = 1'b0;
        d_wr         = 1'b0;
        d_addr       = '0;
        d_wdata      = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        pipe = '0;
        mem.mem_data_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        nvec  = 0;
        nmis  = 0;
        rst_n = 1'b0;
        idle_inputs();
        pipe = '0;
        mem.mem_data_valid = 1'b0;
        @(posedge clk);
        #1;

        // Held in reset with everything asserted: all outputs stay low.
        i_req = 1'b1; i_mem_enable = 1'b1; i_addr = 16'h1111;
        d_req = 1'b1; d_mem_enable = 1'b1; d_wr = 1'b1;
        d_addr = 16'h2222; d_wdata = 16'hFFFF;
        mem.mem_data_valid = 1'b1;
        #1;
        chk("rst_i_grant", 32'(i_grant), 0);
        chk("rst_d_grant", 32'(d_grant), 0);
        chk("rst_mem_en", 32'(mem.mem_enable), 0);
        chk("rst_mem_wr", 32'(mem.mem_wr), 0);
        chk("rst_mem_addr", 32'(mem.mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem.mem_wdata), 0);
        chk("rst_wr_ack", 32'(d_wr_ack), 0);
        chk("rst_i_dv", 32'(i_data_valid), 0);
        chk("rst_d_dv", 32'(d_data_valid), 0);
        chk("rst_spur", 32'(spurious_valid), 0);
        do_reset();

        // I-cache fill alone.
        for (int c = 0; c < 13; c++) begin
            i_req        = (c < 11);
            i_mem_enable = (c < 8);
            i_addr       = 16'h1230 + 16'(2 * c);
            #1;
            chk("t1_i_grant", 32'(i_grant), 32'(c <= 11));
            chk("t1_d_grant", 32'(d_grant), 0);
            chk("t1_mem_en", 32'(mem.mem_enable), 32'(c < 8));
            if (c < 8)
                chk("t1_mem_addr", 32'(mem.mem_addr),
                    32'(16'h1230 + 16'(2 * c)));
            chk("t1_i_dv", 32'(i_data_valid), 32'(c >= 4 && c <= 11));
            chk("t1_d_dv", 32'(d_data_valid), 0);
            tick();
        end
        #1;
        chk("t1_count", 32'(dut.outstanding), 0);
        chk("t1_spur", 32'(spurious_valid), 0);

        // Tie from reset: D wins, I waits and is granted in the first IDLE.
        do_reset();
        for (int c = 0; c < 13; c++) begin
            d_req        = (c < 11);
            d_mem_enable = (c < 8);
            d_addr       = 16'h2000 + 16'(2 * c);
            i_req        = 1'b1;
            i_mem_enable = 1'b1;
            i_addr       = 16'h7770;
            #1;
            if (c <= 11) begin
                chk("t2_d_grant", 32'(d_grant), 1);
                chk("t2_i_grant", 32'(i_grant), 0);
                chk("t2_mem_en", 32'(mem.mem_enable), 32'(c < 8));
                if (c < 8)
                    chk("t2_mem_addr", 32'(mem.mem_addr),
                        32'(16'h2000 + 16'(2 * c)));
                chk("t2_d_dv", 32'(d_data_valid), 32'(c >= 4));
                chk("t2_i_dv", 32'(i_data_valid), 0);
            end else begin
                chk("t2_i_grant_idle", 32'(i_grant), 1);
                chk("t2_d_grant_idle", 32'(d_grant), 0);
                chk("t2_i_mem_en", 32'(mem.mem_enable), 1);
                chk("t2_i_mem_addr", 32'(mem.mem_addr), 32'h7770);
            end
            tick();
        end

        // D write-through held off until I releases.
        do_reset();
        for (int c = 0; c < 9; c++) begin
            i_req        = (c <= 4);
            i_mem_enable = (c <= 1);
            i_addr       = 16'h3000 + 16'(2 * c);
            d_req        = (c >= 1 && c <= 6);
            d_wr         = (c >= 1 && c <= 6);
            d_mem_enable = (c >= 1 && c <= 6);
            d_addr       = 16'h4000;
            d_wdata      = 16'hBEEF;
            #1;
            chk("t3_mem_wr", 32'(mem.mem_wr), 32'(c == 6));
            chk("t3_wr_ack", 32'(d_wr_ack), 32'(c == 6));
            chk("t3_d_grant", 32'(d_grant), 32'(c == 6 || c == 7));
            chk("t3_i_grant", 32'(i_grant), 32'(c <= 5));
            if (c == 6) begin
                chk("t3_mem_addr", 32'(mem.mem_addr), 32'h4000);
                chk("t3_mem_wdata", 32'(mem.mem_wdata), 32'hBEEF);
                chk("t3_mem_en", 32'(mem.mem_enable), 1);
            end
            if (c == 7)
                chk("t3_count", 32'(dut.outstanding), 0);
            tick();
        end

        // I drops req with reads in flight and keeps the grant until drained.
        do_reset();
        for (int c = 0; c < 13; c++) begin
            i_req        = (c < 8);
            i_mem_enable = (c < 8);
            i_addr       = 16'h1230 + 16'(2 * c);
            #1;
            chk("t4_i_grant", 32'(i_grant), 32'(c <= 11));
            chk("t4_i_dv", 32'(i_data_valid), 32'(c >= 4 && c <= 11));
            if (c == 9)
                chk("t4_count_mid", 32'(dut.outstanding), 3);
            tick();
        end
        #1;
        chk("t4_count_end", 32'(dut.outstanding), 0);

        // Valid with nothing outstanding is flagged and sticks.
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            if (c == 0)
                mem.mem_data_valid = 1'b1;
            #1;
            chk("t5_i_dv", 32'(i_data_valid), 0);
            chk("t5_d_dv", 32'(d_data_valid), 0);
            chk("t5_spur", 32'(spurious_valid), 32'(c >= 1));
            tick();
        end
        do_reset();
        #1;
        chk("t5_spur_clr", 32'(spurious_valid), 0);

        // Reset in the middle of an I burst with D waiting.
        for (int c = 0; c < 8; c++) begin
            if (c <= 3) begin
                i_req        = 1'b1;
                i_mem_enable = 1'b1;
                i_addr       = 16'h6000 + 16'(2 * c);
            end else begin
                i_req        = 1'b0;
                i_mem_enable = 1'b0;
            end
            d_req        = (c >= 1);
            d_mem_enable = (c >= 1 && c <= 3);
            d_addr       = 16'h5000;
            d_wr         = 1'b0;
            if (c == 4) rst_n = 1'b0;
            if (c == 5) rst_n = 1'b1;
            #1;
            if (c == 4) begin
                chk("t6_rst_i_grant", 32'(i_grant), 0);
                chk("t6_rst_d_grant", 32'(d_grant), 0);
                chk("t6_rst_mem_en", 32'(mem.mem_enable), 0);
                chk("t6_rst_mem_addr", 32'(mem.mem_addr), 0);
                chk("t6_rst_i_dv", 32'(i_data_valid), 0);
                chk("t6_rst_count", 32'(dut.outstanding), 0);
                chk("t6_rst_spur", 32'(spurious_valid), 0);
            end
            if (c == 5) begin
                chk("t6_d_grant", 32'(d_grant), 1);
                chk("t6_i_grant", 32'(i_grant), 0);
                chk("t6_count", 32'(dut.outstanding), 0);
                chk("t6_mem_addr", 32'(mem.mem_addr), 32'h5000);
            end
            if (c >= 5)
                chk("t6_d_dv", 32'(d_data_valid), 0);
            if (c >= 6) begin
                chk("t6_spur", 32'(spurious_valid), 1);
                chk("t6_d_grant_hold", 32'(d_grant), 1);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
